// File: rtl/nubus_master.sv
// NuBus master sequencer: arbitrates, runs address/data cycles, times out a missing ACK.
// Every output is a flop loaded from the next-state decode, so no input reaches an output combinationally.
//
//   state | meaning
//   IDLE  | waiting for cpu_req
//   ARB   | requesting the bus; minimum two clocks
//   ADDR  | one address clock with bus ownership
//   DATA  | waiting for ACK, timeout counter running
//   ATTN  | one attention clock that closes a locked transaction
//   DONE  | one completion clock; lock released
module nubus_master #(
  parameter int TMO_MAX = 255
) (
  input  logic       nub_clkn,
  input  logic       nub_reset,
  input  logic       cpu_req,
  input  logic       cpu_lock,
  input  logic       cpu_tm1n,
  input  logic       cpu_tm0n,
  input  logic       nub_arbdn,
  input  logic       nub_startn,
  input  logic       nub_ackn,
  input  logic       nub_tm1n,
  input  logic       nub_tm0n,
  output logic       mst_arbcyn,
  output logic       mst_adrcyn,
  output logic       mst_dtacyn,
  output logic       mst_ownern,
  output logic       mst_lockedn,
  output logic       mst_tm1n,
  output logic       mst_tm0n,
  output logic       mst_timeout,
  output logic       mst_busy,
  output logic       mst_done,
  output logic [1:0] mst_status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_DATA,
    S_ATTN,
    S_DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_MAX);

  state_t      state_q, state_d;
  logic        lock_q, lock_d;
  logic        tm1n_d, tm0n_d;
  logic [1:0]  arb_cnt_q;
  logic [7:0]  tmo_cnt_q;
  logic        bus_busy_q;
  logic        arb_ok;
  logic        timeout_d;
  logic [1:0]  status_d;
  logic        arbcyn_d, adrcyn_d, dtacyn_d, ownern_d, lockedn_d, busy_d, done_d;

  // arb_cnt_q is 0 during the first ARB clock, so a nonzero value means the minimum is met
  assign arb_ok = (arb_cnt_q != 2'd0) && !nub_arbdn && !bus_busy_q;

  always_ff @(posedge nub_clkn or posedge nub_reset) begin
    if (nub_reset) begin
      state_q     <= S_IDLE;
      lock_q      <= 1'b0;
      arb_cnt_q   <= 2'd0;
      tmo_cnt_q   <= 8'd0;
      bus_busy_q  <= 1'b0;
      mst_arbcyn  <= 1'b1;
      mst_adrcyn  <= 1'b1;
      mst_dtacyn  <= 1'b1;
      mst_ownern  <= 1'b1;
      mst_lockedn <= 1'b1;
      mst_tm1n    <= 1'b1;
      mst_tm0n    <= 1'b1;
      mst_timeout <= 1'b0;
      mst_busy    <= 1'b0;
      mst_done    <= 1'b0;
      mst_status  <= 2'b00;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;

      if (state_q == S_IDLE)
        arb_cnt_q <= 2'd0;
      else if (state_q == S_ARB && arb_cnt_q != 2'd3)
        arb_cnt_q <= arb_cnt_q + 2'd1;

      if (state_q == S_DATA)
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      else
        tmo_cnt_q <= 8'd0;

      // a foreign ACK in the same clock as START means that tenure already ended
      if (!nub_ackn)
        bus_busy_q <= 1'b0;
      else if (!nub_startn)
        bus_busy_q <= 1'b1;

      mst_arbcyn  <= arbcyn_d;
      mst_adrcyn  <= adrcyn_d;
      mst_dtacyn  <= dtacyn_d;
      mst_ownern  <= ownern_d;
      mst_lockedn <= lockedn_d;
      mst_tm1n    <= tm1n_d;
      mst_tm0n    <= tm0n_d;
      mst_timeout <= timeout_d;
      mst_busy    <= busy_d;
      mst_done    <= done_d;
      mst_status  <= status_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    tm1n_d    = mst_tm1n;
    tm0n_d    = mst_tm0n;
    timeout_d = 1'b0;
    status_d  = mst_status;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          lock_d  = cpu_lock;
          tm1n_d  = cpu_tm1n;
          tm0n_d  = cpu_tm0n;
          state_d = S_ARB;
        end
      end
      S_ARB:  if (arb_ok) state_d = S_ADDR;
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        // ACK takes priority over an expiring timeout in the same clock
        if (!nub_ackn) begin
          status_d = {~nub_tm1n, ~nub_tm0n};
          state_d  = lock_q ? S_ATTN : S_DONE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          status_d  = 2'b11;
          state_d   = S_DONE;
        end
      end
      S_ATTN: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    arbcyn_d  = 1'b1;
    adrcyn_d  = 1'b1;
    dtacyn_d  = 1'b1;
    ownern_d  = 1'b1;
    lockedn_d = 1'b1;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    case (state_d)
      S_ARB: begin
        arbcyn_d  = 1'b0;
        lockedn_d = ~lock_d;
      end
      S_ADDR: begin
        arbcyn_d  = 1'b0;
        adrcyn_d  = 1'b0;
        ownern_d  = 1'b0;
        lockedn_d = ~lock_d;
      end
      S_DATA: begin
        arbcyn_d  = 1'b0;
        dtacyn_d  = 1'b0;
        ownern_d  = 1'b0;
        lockedn_d = ~lock_d;
      end
      S_ATTN: begin
        arbcyn_d  = 1'b0;
        ownern_d  = 1'b0;
        lockedn_d = ~lock_d;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nubus_master.sv
// Directed bench for nubus_master: per-cycle vector table plus hand sequences for
// timeout, ACK at the last count, and reset during a data cycle.
module tb_nubus_master;

  logic       nub_clkn = 1'b0;
  logic       nub_reset;
  logic       cpu_req, cpu_lock, cpu_tm1n, cpu_tm0n;
  logic       nub_arbdn, nub_startn, nub_ackn, nub_tm1n, nub_tm0n;
  logic       mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn;
  logic       mst_tm1n, mst_tm0n, mst_timeout, mst_busy, mst_done;
  logic [1:0] mst_status;
  logic [11:0] obs;

  int checks = 0;
  int errors = 0;

  nubus_master #(.TMO_MAX(255)) dut (
    .nub_clkn    (nub_clkn),
    .nub_reset   (nub_reset),
    .cpu_req     (cpu_req),
    .cpu_lock    (cpu_lock),
    .cpu_tm1n    (cpu_tm1n),
    .cpu_tm0n    (cpu_tm0n),
    .nub_arbdn   (nub_arbdn),
    .nub_startn  (nub_startn),
    .nub_ackn    (nub_ackn),
    .nub_tm1n    (nub_tm1n),
    .nub_tm0n    (nub_tm0n),
    .mst_arbcyn  (mst_arbcyn),
    .mst_adrcyn  (mst_adrcyn),
    .mst_dtacyn  (mst_dtacyn),
    .mst_ownern  (mst_ownern),
    .mst_lockedn (mst_lockedn),
    .mst_tm1n    (mst_tm1n),
    .mst_tm0n    (mst_tm0n),
    .mst_timeout (mst_timeout),
    .mst_busy    (mst_busy),
    .mst_done    (mst_done),
    .mst_status  (mst_status)
  );

  always #5 nub_clkn = ~nub_clkn;

  // {arbcyn, adrcyn, dtacyn, ownern, lockedn, tm1n, tm0n, timeout, busy, done, status}
  assign obs = {mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern, mst_lockedn,
                mst_tm1n, mst_tm0n, mst_timeout, mst_busy, mst_done, mst_status};

  localparam logic [11:0] RST_EXP = 12'b11111_11_0_0_0_00;

  // in = {req, lock, tm1n, tm0n, arbdn, startn, ackn, bus_tm1n, bus_tm0n}
  typedef struct {
    string       name;
    logic [8:0]  in;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic set_in(input logic [8:0] v);
    {cpu_req, cpu_lock, cpu_tm1n, cpu_tm0n, nub_arbdn, nub_startn, nub_ackn, nub_tm1n, nub_tm0n} = v;
  endtask

  task automatic step();
    @(posedge nub_clkn);
    #1;
  endtask

  task automatic check(input string nm, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", nm, obs, exp);
    end
  endtask

  task automatic check1(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic wait_data(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mst_dtacyn == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    bit saw_to;

    // unlocked transfer, tm=10, ACK on third DATA clock
    vecs.push_back('{"u_arb1",   9'b1_0_10_0_1_1_11, 12'b01111_10_0_1_0_00});
    vecs.push_back('{"u_arb2",   9'b0_0_10_0_1_1_11, 12'b01111_10_0_1_0_00});
    vecs.push_back('{"u_addr",   9'b0_0_10_0_1_1_11, 12'b00101_10_0_1_0_00});
    vecs.push_back('{"u_data1",  9'b0_0_10_0_1_1_11, 12'b01001_10_0_1_0_00});
    vecs.push_back('{"u_data2",  9'b0_0_10_0_1_1_11, 12'b01001_10_0_1_0_00});
    vecs.push_back('{"u_done",   9'b0_0_10_0_1_0_11, 12'b11111_10_0_1_1_00});
    vecs.push_back('{"u_idle",   9'b0_0_10_0_1_1_11, 12'b11111_10_0_0_0_00});
    // locked transfer, tm=01, arbitration lost twice, ACK in ADDR ignored
    vecs.push_back('{"l_arb1",   9'b1_1_01_0_1_1_11, 12'b01110_01_0_1_0_00});
    vecs.push_back('{"l_arb2",   9'b1_0_11_1_1_1_11, 12'b01110_01_0_1_0_00});
    vecs.push_back('{"l_arb3",   9'b1_0_11_1_1_1_11, 12'b01110_01_0_1_0_00});
    vecs.push_back('{"l_addr",   9'b0_0_11_0_1_1_11, 12'b00100_01_0_1_0_00});
    vecs.push_back('{"l_data",   9'b0_0_11_0_1_0_00, 12'b01000_01_0_1_0_00});
    vecs.push_back('{"l_attn",   9'b0_0_11_0_1_0_01, 12'b01100_01_0_1_0_10});
    vecs.push_back('{"l_done",   9'b0_0_11_0_1_1_11, 12'b11111_01_0_1_1_10});
    vecs.push_back('{"l_idle",   9'b0_0_11_0_1_1_11, 12'b11111_01_0_0_0_10});
    // foreign tenure: START during ARB, then START+ACK together (clear wins)
    vecs.push_back('{"b_arb1",   9'b1_0_11_0_1_1_11, 12'b01111_11_0_1_0_10});
    vecs.push_back('{"b_start",  9'b0_0_11_0_0_1_11, 12'b01111_11_0_1_0_10});
    vecs.push_back('{"b_hold1",  9'b0_0_11_0_1_1_11, 12'b01111_11_0_1_0_10});
    vecs.push_back('{"b_hold2",  9'b0_0_11_0_1_1_11, 12'b01111_11_0_1_0_10});
    vecs.push_back('{"b_ack",    9'b0_0_11_0_0_0_11, 12'b01111_11_0_1_0_10});
    vecs.push_back('{"b_addr",   9'b0_0_11_0_1_1_11, 12'b00101_11_0_1_0_10});
    vecs.push_back('{"b_data",   9'b0_0_11_0_1_1_11, 12'b01001_11_0_1_0_10});
    vecs.push_back('{"b_done",   9'b0_0_11_0_1_0_10, 12'b11111_11_0_1_1_01});
    vecs.push_back('{"b_idle",   9'b0_0_11_0_1_1_11, 12'b11111_11_0_0_0_01});

    nub_reset = 1'b1;
    set_in(9'b0_0_11_1_1_1_11);
    #12;
    check("reset_state", RST_EXP);
    step();
    nub_reset = 1'b0;
    step();
    check("idle_no_req", RST_EXP);

    foreach (vecs[i]) begin
      set_in(vecs[i].in);
      step();
      check(vecs[i].name, vecs[i].exp);
    end

    // timeout: 256 DATA clocks without ACK
    set_in(9'b1_0_11_0_1_1_11);
    step();
    set_in(9'b0_0_11_0_1_1_11);
    wait_data(ok);
    check1("tmo_reach_data", int'(ok), 1);
    n = 1;
    saw_to = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (mst_dtacyn == 1'b0) begin
        n++;
        if (mst_timeout) saw_to = 1'b1;
      end else begin
        break;
      end
    end
    check1("tmo_data_clocks", n, 256);
    check1("tmo_early_pulse", int'(saw_to), 0);
    check("tmo_done", 12'b11111_11_1_1_1_11);
    step();
    check("tmo_idle", 12'b11111_11_0_0_0_11);

    // ACK on the last count: no timeout, status from TM*
    set_in(9'b1_0_11_0_1_1_11);
    step();
    set_in(9'b0_0_11_0_1_1_11);
    wait_data(ok);
    check1("a255_reach_data", int'(ok), 1);
    for (int i = 0; i < 255; i++) step();
    check1("a255_still_data", int'(mst_dtacyn), 0);
    set_in(9'b0_0_11_0_1_0_01);
    step();
    check("a255_done", 12'b11111_11_0_1_1_10);
    set_in(9'b0_0_11_0_1_1_11);
    step();
    check("a255_idle", 12'b11111_11_0_0_0_10);

    // reset mid-DATA on a locked transfer, then a fresh request
    set_in(9'b1_1_00_0_1_1_11);
    step();
    set_in(9'b0_0_00_0_1_1_11);
    wait_data(ok);
    check1("rst_reach_data", int'(ok), 1);
    check("rst_pre_data", 12'b01000_00_0_1_0_10);
    #3 nub_reset = 1'b1;
    #1 check("rst_async", RST_EXP);
    step();
    check("rst_held", RST_EXP);
    #2 nub_reset = 1'b0;
    set_in(9'b1_0_10_0_1_1_11);
    step();
    check("rst_first_req", 12'b01111_10_0_1_0_00);
    set_in(9'b0_0_10_0_1_1_11);
    wait_data(ok);
    check1("rst_new_data", int'(ok), 1);
    set_in(9'b0_0_10_0_1_0_00);
    step();
    check("rst_new_done", 12'b11111_10_0_1_1_11);
    set_in(9'b0_0_10_0_1_1_11);
    step();
    check("rst_new_idle", 12'b11111_10_0_0_0_11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nubus_master.md
NUBUS_MASTER -- requirements
Module: nubus_master

Interface
REQ-001 SHALL have port nub_clkn, input, 1, NuBus clock; all state changes on its rising edge.
REQ-002 SHALL have port nub_reset, input, 1, reset; asynchronous, active-high; one clock domain only.
REQ-003 SHALL have inputs cpu_req (1, start transaction, level), cpu_lock (1, locked transaction), cpu_tm1n and cpu_tm0n (1 each, transfer mode for address cycle).
REQ-004 SHALL have inputs nub_arbdn (1, arbitration won, active-low), nub_startn (1, sampled START*) and nub_ackn (1, sampled ACK*).
REQ-005 SHALL have inputs nub_tm1n and nub_tm0n (1 each, sampled TM* status at ACK).
REQ-006 SHALL have outputs mst_arbcyn, mst_adrcyn, mst_dtacyn, mst_ownern and mst_lockedn (1 each, active-low cycle flags), feeding the bus driver.
REQ-007 SHALL have outputs mst_tm1n and mst_tm0n (1 each, latched transfer mode) and mst_timeout (1, one-clock timeout pulse).
REQ-008 SHALL have outputs mst_busy (1, not IDLE), mst_done (1, one-clock completion pulse) and mst_status (2, {~TM1*,~TM0*} captured at ACK).
REQ-009 SHALL have parameter TMO_MAX, default 255, giving the DATA-state clocks before timeout; the counter SHALL be 8 bits.

Function
REQ-010 SHALL implement states IDLE, ARB, ADDR, DATA, ATTN and DONE, one-hot or encoded.
REQ-011 IDLE: on cpu_req=1, latch cpu_lock, cpu_tm1n and cpu_tm0n, clear the arbitration counter, and go to ARB; cpu_req outside IDLE SHALL be ignored.
REQ-012 ARB: mst_arbcyn=0, plus mst_lockedn=0 if the lock was latched; the block SHALL stay in ARB for at least 2 clocks.
REQ-013 ARB exit: go to ADDR when the 2-clock minimum is met, nub_arbdn=0 and the bus-busy flag is 0; otherwise hold ARB indefinitely.
REQ-014 Bus-busy flag: set on sampled nub_startn=0 and cleared on sampled nub_ackn=0; if both occur in the same cycle, clear wins.
REQ-015 ADDR: exactly 1 clock with mst_ownern=0, mst_adrcyn=0 and mst_arbcyn=0; mst_tm1n/mst_tm0n SHALL equal the latched values; then go to DATA.
REQ-016 DATA: mst_ownern=0, mst_dtacyn=0 and mst_arbcyn=0; the timeout counter increments each clock from 0; nub_ackn sampled during ADDR SHALL be ignored.
REQ-017 DATA on nub_ackn=0: capture mst_status={~nub_tm1n,~nub_tm0n}; go to ATTN if locked, otherwise DONE.
REQ-018 DATA on counter=TMO_MAX with no ACK: pulse mst_timeout=1 for that clock, set mst_status=2'b11 and go to DONE; ACK in the same clock SHALL win with no timeout pulse.
REQ-019 ATTN (locked only): exactly 1 clock with mst_ownern=0, mst_arbcyn=0, mst_adrcyn=1, mst_dtacyn=1 and mst_lockedn=0; then go to DONE.
REQ-020 DONE: exactly 1 clock with mst_done=1 and all cycle flags high; mst_lockedn SHALL be released here; then go to IDLE.
REQ-021 mst_status SHALL hold until the next capture.
REQ-022 mst_busy SHALL be 1 in every state except IDLE.
REQ-023 All outputs SHALL be registered; there SHALL be no combinational path from input to output.
REQ-024 Latency: request to ADDR is at least 3 clocks; an unlocked transaction SHALL end with mst_done exactly 1 clock after the ACK sample.

Reset
REQ-025 On nub_reset=1, immediately enter IDLE: all mst_*n outputs=1, mst_tm1n=mst_tm0n=1, mst_timeout=0, mst_done=0, mst_busy=0, mst_status=2'b00, counters=0, busy flag=0.
REQ-026 Reset asserted mid-transaction SHALL abort it with no mst_done pulse; the block SHALL accept cpu_req on the first clock after reset deasserts.

Verification
REQ-027 Unlocked transfer: cpu_req with tm=2'b10, nub_arbdn=0, ACK on the 3rd DATA clock with TM*=11 -> ADDR 1 clock, mst_tm1n=1 and mst_tm0n=0, mst_status=00, mst_done 1 clock after the ACK.
REQ-028 Locked transfer: cpu_lock=1 -> mst_lockedn=0 from ARB through ATTN, one ATTN clock, release in DONE.
REQ-029 Timeout: no ACK -> mst_timeout pulses on DATA clock 256, mst_status=11, then DONE and IDLE.
REQ-030 Busy bus: foreign START seen during ARB with nub_arbdn=0 -> stay in ARB until ACK is sampled, ADDR on the next clock.
REQ-031 ACK coincident with counter=255 -> no mst_timeout pulse, status taken from TM*.
REQ-032 nub_reset pulse during DATA -> all outputs at reset values asynchronously, no mst_done; a new cpu_req completes normally.
